// File: rtl/game_flow_ctrl.sv
// Game-flow controller: TITLE/PLAY/HURT/OVER sequencing, lives with
// invulnerability frames, BCD score, attack cooldown and colour-flash code.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_frame_end           one-cycle pulse per video frame
//   i_start_btn           debounced start button level
//   i_attack_released     one-cycle pulse on attack-button release
//   i_player_hit          player/dragon collision level
//   i_dragon_hit          sword/dragon collision level
//   o_state               00 TITLE, 01 PLAY, 10 HURT, 11 OVER
//   o_lives               remaining lives
//   o_invuln              high in HURT
//   o_attack_enable       sword may damage dragon
//   o_score               BCD score, digit 0 in [3:0]
//   o_flash               00 none, 01 red, 10 blue, 11 magenta
//   o_play_reset          one-cycle pulse on game start
//   o_game_over           high in OVER
module game_flow_ctrl #(
    parameter int LIVES        = 3,
    parameter int LIFE_W       = 2,
    parameter int IFRAMES      = 60,
    parameter int COOLDOWN     = 255,
    parameter int CD_W         = 16,
    parameter int SCORE_DIGITS = 4,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_frame_end,
    input  logic                      i_start_btn,
    input  logic                      i_attack_released,
    input  logic                      i_player_hit,
    input  logic                      i_dragon_hit,
    output logic [1:0]                o_state,
    output logic [LIFE_W-1:0]         o_lives,
    output logic                      o_invuln,
    output logic                      o_attack_enable,
    output logic [4*SCORE_DIGITS-1:0] o_score,
    output logic [1:0]                o_flash,
    output logic                      o_play_reset,
    output logic                      o_game_over
);

    localparam int SW = 4 * SCORE_DIGITS;

    typedef enum logic [1:0] {
        S_TITLE = 2'b00,
        S_PLAY  = 2'b01,
        S_HURT  = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [LIFE_W-1:0] r_lives, w_lives_nxt;
    logic [7:0]        r_iframe, w_iframe_nxt;
    logic [SW-1:0]     r_score, w_score_nxt, w_score_inc;
    logic [CD_W-1:0]   r_cd, w_cd_nxt;
    logic [1:0]        r_flash, w_flash_nxt, w_cause;
    logic [7:0]        r_hold, w_hold_nxt;
    logic              r_play_reset, w_play_reset_nxt;
    logic              r_start_q, r_dhit_q;
    logic              w_start_edge, w_dhit_edge, w_active;
    logic              w_all9, w_carry, w_idle_state;

    assign w_start_edge = i_start_btn & ~r_start_q;
    assign w_dhit_edge  = i_dragon_hit & ~r_dhit_q;
    assign w_active     = (r_state == S_PLAY) || (r_state == S_HURT);

    // BCD +1 with ripple carry; w_all9 flags the saturation point.
    always_comb begin
        w_score_inc = r_score;
        w_all9      = 1'b1;
        w_carry     = 1'b1;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (r_score[4*d +: 4] != 4'd9) w_all9 = 1'b0;
            if (w_carry) begin
                if (r_score[4*d +: 4] >= 4'd9) begin
                    w_score_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*d +: 4] = r_score[4*d +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_lives_nxt      = r_lives;
        w_iframe_nxt     = r_iframe;
        w_score_nxt      = r_score;
        w_play_reset_nxt = 1'b0;
        unique case (r_state)
            S_TITLE: begin
                if (w_start_edge) begin
                    w_state_nxt      = S_PLAY;
                    w_play_reset_nxt = 1'b1;
                    w_lives_nxt      = LIFE_W'(LIVES);
                    w_score_nxt      = '0;
                end
            end
            S_PLAY: begin
                if (i_frame_end && i_player_hit) begin
                    if (r_lives == LIFE_W'(1)) begin
                        w_lives_nxt = '0;
                        w_state_nxt = S_OVER;
                    end else begin
                        w_lives_nxt  = r_lives - LIFE_W'(1);
                        w_iframe_nxt = 8'(IFRAMES);
                        w_state_nxt  = S_HURT;
                    end
                end
            end
            S_HURT: begin
                if (i_frame_end) begin
                    if (r_iframe <= 8'd1) begin
                        w_iframe_nxt = 8'd0;
                        w_state_nxt  = S_PLAY;
                    end else begin
                        w_iframe_nxt = r_iframe - 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (w_start_edge) w_state_nxt = S_TITLE;
            end
            default: w_state_nxt = S_TITLE;
        endcase
        // Eligibility uses the state of the edge cycle.
        if (w_dhit_edge && w_active && !w_all9) w_score_nxt = w_score_inc;
    end

    always_comb begin
        w_cd_nxt = r_cd;
        if (i_attack_released)  w_cd_nxt = CD_W'(COOLDOWN);
        else if (r_cd != '0)    w_cd_nxt = r_cd - CD_W'(1);
    end

    // Flash is blanked both in and on entry to TITLE/OVER so the
    // fatal hit never shows a flash alongside the OVER state.
    always_comb begin
        w_cause      = {i_dragon_hit, i_player_hit & (r_state != S_HURT)};
        w_flash_nxt  = r_flash;
        w_hold_nxt   = r_hold;
        w_idle_state = (r_state == S_TITLE) || (r_state == S_OVER) ||
                       (w_state_nxt == S_TITLE) || (w_state_nxt == S_OVER);
        if (i_frame_end) begin
            if (w_cause != 2'b00) begin
                w_flash_nxt = w_cause;
                w_hold_nxt  = 8'(FLASH_FRAMES);
            end else if (r_hold > 8'd1) begin
                w_hold_nxt = r_hold - 8'd1;
            end else begin
                w_hold_nxt  = 8'd0;
                w_flash_nxt = 2'b00;
            end
        end
        if (w_idle_state) begin
            w_flash_nxt = 2'b00;
            w_hold_nxt  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_TITLE;
            r_lives      <= LIFE_W'(LIVES);
            r_iframe     <= 8'd0;
            r_score      <= '0;
            r_cd         <= '0;
            r_flash      <= 2'b00;
            r_hold       <= 8'd0;
            r_play_reset <= 1'b0;
            r_start_q    <= 1'b0;
            r_dhit_q     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_iframe     <= w_iframe_nxt;
            r_score      <= w_score_nxt;
            r_cd         <= w_cd_nxt;
            r_flash      <= w_flash_nxt;
            r_hold       <= w_hold_nxt;
            r_play_reset <= w_play_reset_nxt;
            r_start_q    <= i_start_btn;
            r_dhit_q     <= i_dragon_hit;
        end
    end

    assign o_state         = r_state;
    assign o_lives         = r_lives;
    assign o_invuln        = (r_state == S_HURT);
    assign o_game_over     = (r_state == S_OVER);
    assign o_attack_enable = (r_cd == '0) && w_active;
    assign o_score         = r_score;
    assign o_flash         = r_flash;
    assign o_play_reset    = r_play_reset;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: table of per-cycle vectors plus
// hand sequences for cooldown, score carry/saturation, flash and reset.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fe = 1'b0, sb = 1'b0, ar = 1'b0, ph = 1'b0, dh = 1'b0;
    logic [1:0]  st, lv, fl;
    logic        inv, ae, pr, go;
    logic [15:0] sc;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .LIVES(3), .LIFE_W(2), .IFRAMES(3), .COOLDOWN(5),
        .CD_W(16), .SCORE_DIGITS(4), .FLASH_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_frame_end(fe), .i_start_btn(sb),
        .i_attack_released(ar), .i_player_hit(ph),
        .i_dragon_hit(dh),
        .o_state(st), .o_lives(lv), .o_invuln(inv),
        .o_attack_enable(ae), .o_score(sc), .o_flash(fl),
        .o_play_reset(pr), .o_game_over(go)
    );

    typedef struct {
        logic       f, s, a, p, d;
        logic [1:0] est, elv, efl;
        logic       epr, eae;
        logic [15:0] esc;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic f, s, a, p, d);
        fe = f; sb = s; ar = a; ph = p; dh = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string t, input logic [1:0] est,
                           input logic [1:0] elv, input logic [1:0] efl,
                           input logic epr, input logic eae,
                           input logic [15:0] esc);
        chk({t, " state"}, 32'(st), 32'(est));
        chk({t, " lives"}, 32'(lv), 32'(elv));
        chk({t, " flash"}, 32'(fl), 32'(efl));
        chk({t, " play_reset"}, 32'(pr), 32'(epr));
        chk({t, " attack_en"}, 32'(ae), 32'(eae));
        chk({t, " score"}, 32'(sc), 32'(esc));
        chk({t, " invuln"}, 32'(inv), 32'(est == 2'd2));
        chk({t, " game_over"}, 32'(go), 32'(est == 2'd3));
    endtask

    task automatic add(input logic f, s, a, p, d,
                       input logic [1:0] est, elv, efl,
                       input logic epr, eae, input logic [15:0] esc);
        vec_t v;
        v.f = f; v.s = s; v.a = a; v.p = p; v.d = d;
        v.est = est; v.elv = elv; v.efl = efl;
        v.epr = epr; v.eae = eae; v.esc = esc;
        vt.push_back(v);
    endtask

    task automatic dedge();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        // start: one play_reset despite 10 cycles of start held
        add(0,1,0,0,0, 1,3,0,1,1,0);
        for (int i = 0; i < 9; i++) add(0,1,0,0,0, 1,3,0,0,1,0);
        add(0,0,0,0,0, 1,3,0,0,1,0);
        add(0,1,0,0,0, 1,3,0,0,1,0);
        add(0,0,0,0,0, 1,3,0,0,1,0);
        // life loss and i-frames
        add(0,0,0,1,0, 1,3,0,0,1,0);
        add(1,0,0,1,0, 2,2,1,0,1,0);
        add(0,0,0,1,0, 2,2,1,0,1,0);
        add(1,0,0,1,0, 2,2,1,0,1,0);
        add(1,0,0,1,0, 2,2,0,0,1,0);
        add(1,0,0,1,0, 1,2,0,0,1,0);
        add(0,0,0,1,0, 1,2,0,0,1,0);
        add(1,0,0,1,0, 2,1,1,0,1,0);
        add(1,0,0,0,0, 2,1,1,0,1,0);
        add(1,0,0,0,0, 2,1,0,0,1,0);
        add(1,0,0,0,0, 1,1,0,0,1,0);
        // game over, dragon edges in OVER/TITLE, restart
        add(1,0,0,1,0, 3,0,0,0,0,0);
        add(0,0,0,0,1, 3,0,0,0,0,0);
        add(0,1,0,0,0, 0,0,0,0,0,0);
        add(0,1,0,0,1, 0,0,0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0,0);
        add(0,1,0,0,0, 1,3,0,1,1,0);
        add(0,0,0,0,0, 1,3,0,0,1,0);

        rst_n = 1'b0;
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        chk_all("reset", 0, 3, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].f, vt[i].s, vt[i].a, vt[i].p, vt[i].d);
            chk_all($sformatf("vec%0d", i), vt[i].est, vt[i].elv,
                    vt[i].efl, vt[i].epr, vt[i].eae, vt[i].esc);
        end

        // cooldown single pulse: low t+1..t+5, high t+6
        step(0,0,1,0,0);
        chk("cd1 t+1", 32'(ae), 0);
        for (int k = 2; k <= 5; k++) begin
            step(0,0,0,0,0);
            chk($sformatf("cd1 t+%0d", k), 32'(ae), 0);
        end
        step(0,0,0,0,0);
        chk("cd1 t+6", 32'(ae), 1);

        // second pulse at t+3: low through t+8, high t+9
        for (int k = 0; k < 9; k++) begin
            step(0, 0, (k == 0 || k == 3), 0, 0);
            chk($sformatf("cd2 t+%0d", k + 1), 32'(ae), 32'(k == 8));
        end

        // score
        dedge();
        chk("score first", 32'(sc), 32'h0001);
        step(0,0,0,0,1); step(0,0,0,0,1); step(0,0,0,0,1);
        step(0,0,0,0,0);
        chk("score held level", 32'(sc), 32'h0002);
        for (int k = 0; k < 7; k++) dedge();
        chk("score 0009", 32'(sc), 32'h0009);
        for (int k = 0; k < 10; k++) dedge();
        chk("score 0019", 32'(sc), 32'h0019);
        for (int k = 0; k < 81; k++) dedge();
        chk("score 0100", 32'(sc), 32'h0100);
        for (int k = 0; k < 9899; k++) dedge();
        chk("score 9999", 32'(sc), 32'h9999);
        dedge();
        chk("score sat", 32'(sc), 32'h9999);

        // flash both causes, hold one frame, then clear
        step(1,0,0,1,1); chk_all("fl both", 2, 2, 3, 0, 1, 16'h9999);
        step(1,0,0,0,0); chk_all("fl hold", 2, 2, 3, 0, 1, 16'h9999);
        step(1,0,0,0,0); chk_all("fl clr", 2, 2, 0, 0, 1, 16'h9999);
        step(1,0,0,0,0); chk_all("fl exit", 1, 2, 0, 0, 1, 16'h9999);
        step(1,0,0,1,0); chk_all("hit2", 2, 1, 1, 0, 1, 16'h9999);
        step(1,0,0,0,0);
        step(1,0,0,0,0);
        step(1,0,0,0,0); chk_all("hurt2 exit", 1, 1, 0, 0, 1, 16'h9999);
        step(1,0,0,1,0); chk_all("over", 3, 0, 0, 0, 0, 16'h9999);
        step(0,1,0,0,0); chk_all("to title", 0, 0, 0, 0, 0, 16'h9999);

        // mid-game reset
        step(0,0,0,0,0);
        step(0,1,0,0,0); chk_all("restart", 1, 3, 0, 1, 1, 0);
        step(0,0,1,0,0);
        step(1,0,0,1,0); chk_all("pre rst", 2, 2, 1, 0, 0, 0);
        rst_n = 1'b0;
        step(0,0,0,0,0); chk_all("mid rst", 0, 3, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0,1,0,0,0); chk_all("post rst", 1, 3, 0, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
